reset_tick_gen: RTL and testbench
=================================

Name: reset_tick_gen

Overview:
Parametrised successor to the board-level power-on reset sequencer and fixed tick divider. It generates a programmable-rate tick and a square-wave slow clock from the system clock. It sequences a power-on reset of programmable length and adds a debounced, synchronised manual-reset button combo that replaces the old asynchronous manual path. It sits in the FPGA top wrapper and drives the design's reset and slow timebase from one clock domain.

Parameters:
TICK_DIV, 120000, system clocks per tick; must be >= 2. Default gives 100 Hz from 12 MHz.
NUM_BTN, 21, width of the push-button bus.
COMBO_MASK, 21'h010009, buttons that must all be held to request a manual reset (default pb[16], pb[3], pb[0]); must be nonzero.
DEBOUNCE_TICKS, 2, consecutive ticks the combo must be held before it is accepted; must be >= 1.
HOLD_TICKS, 4, tick periods sys_rst stays high after power-on or combo release; must be >= 1.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
pb  input  NUM_BTN  raw push buttons, asynchronous to clk
pb_sync  output  NUM_BTN  pb after a 2-flop synchroniser
tick  output  1  one-clk pulse, once every TICK_DIV clocks
tick_level  output  1  toggles on every tick (period 2*TICK_DIV)
sys_rst  output  1  active-high reset to the design
sys_rst_n  output  1  always the inverse of sys_rst
por_done  output  1  sticky; high once the first RUN entry occurs after n_rst

Behaviour:
- All state is reset asynchronously by n_rst low.
- Reset values: pb_sync=0, tick=0, tick_level=0, sys_rst=0, sys_rst_n=1, por_done=0, state=POR_LOW. All counters are 0.
- Synchroniser: 2 flops per bit. pb_sync lags pb by 2 clk edges. All internal logic uses pb_sync only.
- Divider:
  - The counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered and is 1 for exactly the cycle after the counter reaches TICK_DIV-1. The first tick follows the TICK_DIV-th edge after n_rst release.
  - tick_level flips on the same edge that tick rises.
  - The divider free-runs in every state.
- Combo:
  - combo_raw = AND over bits i with COMBO_MASK[i]=1 of pb_sync[i]. Unmasked buttons are ignored.
  - The debounce counter clears whenever combo_raw=0, and increments (saturating) on each tick while combo_raw=1.
  - combo_valid = (counter == DEBOUNCE_TICKS).
- FSM (evaluated every clk; combo_valid has top priority from any state):
  - POR_LOW: sys_rst=0, giving a clean low-to-high edge. On tick → HOLD, hold count=0.
  - HOLD: sys_rst=1. On tick: if hold count == HOLD_TICKS-1 → RUN, else hold count+1.
  - RUN: sys_rst=0. por_done is set on entry and held until n_rst.
  - MANUAL: sys_rst=1. When combo_raw=0 → HOLD with hold count=0. Any partial release counts as release.
  - combo_valid in any state → MANUAL. A tick on the same cycle is ignored for hold counting.
- sys_rst and sys_rst_n are registered and update on the same edge as the state register.
- Timing results:
  - After power-on, sys_rst is low for 1 tick period, then high for exactly HOLD_TICKS tick periods.
  - After combo release, sys_rst stays high continuously for HOLD_TICKS further tick periods.
- Boundary conditions:
  - A combo held shorter than DEBOUNCE_TICKS ticks has no effect.
  - Holding the combo indefinitely keeps sys_rst high indefinitely.
  - n_rst low at any time, including mid-HOLD or mid-MANUAL, returns everything to reset values immediately and restarts the sequence from POR_LOW.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, NUM_BTN=4, COMBO_MASK=4'b1001, DEBOUNCE_TICKS=2, HOLD_TICKS=3.
1. Power-on, pb=0 → tick pulses follow edges 4, 8, 12, 16 after n_rst release. sys_rst goes 1 at edge 4 and 0 at edge 16 (12 clks high). por_done rises at edge 16. sys_rst_n is always the inverse of sys_rst.
2. Free run for 40 clks → tick_level toggles every 4 clks (period 8); exactly one tick per 4 clks.
3. In RUN, hold pb=4'b1001 → sys_rst rises on the 2nd tick after pb_sync shows the combo. Hold pb=4'b0001 or 4'b0110 for 10 ticks instead → sys_rst stays 0.
4. In RUN, hold pb=4'b1001 for 1 tick, then release → no reset, and the debounce counter reads 0. Reapply the combo → 2 full ticks are required again.
5. In MANUAL, release pb → sys_rst stays high through exactly 3 more ticks, then drops. por_done stays 1 throughout.
6. Assert n_rst mid-HOLD and mid-MANUAL → outputs take reset values with no clk edge needed. After release, scenario 1 timing repeats exactly.

Source files
------------

// File: rtl/reset_tick_gen.sv
// reset_tick_gen: programmable tick / slow-clock divider plus a power-on and
// debounced button-combo reset sequencer, all in the clk domain.
module reset_tick_gen #(
    parameter int unsigned        TICK_DIV       = 120000,
    parameter int unsigned        NUM_BTN        = 21,
    parameter logic [NUM_BTN-1:0] COMBO_MASK     = NUM_BTN'(21'h010009),
    parameter int unsigned        DEBOUNCE_TICKS = 2,
    parameter int unsigned        HOLD_TICKS     = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_BTN-1:0] pb,
    output logic [NUM_BTN-1:0] pb_sync,
    output logic               tick,
    output logic               tick_level,
    output logic               sys_rst,
    output logic               sys_rst_n,
    output logic               por_done
);

    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] ST_POR_LOW = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_MANUAL  = 2'd3;

    logic [NUM_BTN-1:0] pb_meta;
    logic [CNT_W-1:0]   div_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_nxt;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               sys_rst_nxt;
    logic               por_done_nxt;

    logic tick_c;
    logic combo_raw_c;
    logic combo_valid_c;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pb_meta <= '0;
            pb_sync <= '0;
        end else begin
            pb_meta <= pb;
            pb_sync <= pb_meta;
        end
    end

    // Free-running divider; tick_c marks the edge on which tick rises
    assign tick_c = (div_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt    <= '0;
            tick       <= 1'b0;
            tick_level <= 1'b0;
        end else begin
            tick <= tick_c;
            if (tick_c) begin
                div_cnt    <= '0;
                tick_level <= ~tick_level;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // Unmasked buttons forced high so they never block the AND
    assign combo_raw_c   = &(pb_sync | ~COMBO_MASK);
    assign combo_valid_c = (deb_cnt == DEB_W'(DEBOUNCE_TICKS));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            deb_cnt <= '0;
        end else if (!combo_raw_c) begin
            deb_cnt <= '0;
        end else if (tick_c && !combo_valid_c) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Sequencer state register and registered reset outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_POR_LOW;
            hold_cnt  <= '0;
            sys_rst   <= 1'b0;
            sys_rst_n <= 1'b1;
            por_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            sys_rst   <= sys_rst_nxt;
            sys_rst_n <= ~sys_rst_nxt;
            por_done  <= por_done_nxt;
        end
    end

    // Next-state logic; an accepted combo overrides everything, including a coincident tick
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (combo_valid_c) begin
            state_nxt    = ST_MANUAL;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                ST_POR_LOW: begin
                    if (tick_c) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = '0;
                    end
                end
                ST_HOLD: begin
                    if (tick_c) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            state_nxt = ST_RUN;
                        end else begin
                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    state_nxt = ST_RUN;
                end
                ST_MANUAL: begin
                    if (!combo_raw_c) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = ST_POR_LOW;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
        sys_rst_nxt  = (state_nxt == ST_HOLD) || (state_nxt == ST_MANUAL);
        por_done_nxt = por_done || (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_reset_tick_gen.sv
// Directed bench for reset_tick_gen: power-on timing, divider, combo debounce,
// manual reset release and asynchronous reset mid-sequence.
module tb_reset_tick_gen;

    localparam int unsigned TICK_DIV       = 4;
    localparam int unsigned NUM_BTN        = 4;
    localparam int unsigned DEBOUNCE_TICKS = 2;
    localparam int unsigned HOLD_TICKS     = 3;
    localparam logic [3:0]  COMBO_MASK     = 4'b1001;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] pb = 4'b0000;
    logic [3:0] pb_sync;
    logic       tick;
    logic       tick_level;
    logic       sys_rst;
    logic       sys_rst_n;
    logic       por_done;

    int checks = 0;
    int errors = 0;
    int ec = 0;

    always #5 clk = ~clk;

    reset_tick_gen #(
        .TICK_DIV      (TICK_DIV),
        .NUM_BTN       (NUM_BTN),
        .COMBO_MASK    (COMBO_MASK),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .HOLD_TICKS    (HOLD_TICKS)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pb        (pb),
        .pb_sync   (pb_sync),
        .tick      (tick),
        .tick_level(tick_level),
        .sys_rst   (sys_rst),
        .sys_rst_n (sys_rst_n),
        .por_done  (por_done)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic do_power_on();
        n_rst = 1'b0;
        pb    = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        ec    = 0;
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 4; i++) begin
            if (ec % 4 == phase) break;
            step();
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        pb    = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pb_sync, tick, tick_level, sys_rst, sys_rst_n, por_done} !== 9'b0000_0001_0) begin
            errors++;
            $display("FAIL reset_values: pb_sync=%b tick=%b lvl=%b rst=%b rst_n=%b done=%b, expected 0000 0 0 0 1 0",
                     pb_sync, tick, tick_level, sys_rst, sys_rst_n, por_done);
        end
        checks++;
        if (int'(dut.deb_cnt) !== 0) begin
            errors++;
            $display("FAIL reset_deb_cnt: got %0d expected 0", dut.deb_cnt);
        end
        pb = 4'b0000;
    endtask

    task automatic test_power_on(input string name);
        logic e_tick, e_lvl, e_rst, e_done;
        do_power_on();
        for (int k = 1; k <= 20; k++) begin
            step();
            e_tick = (ec % 4 == 0);
            e_lvl  = ((ec / 4) % 2) == 1;
            e_rst  = (ec >= 4) && (ec < 16);
            e_done = (ec >= 16);
            checks++;
            if ({tick, tick_level, sys_rst, sys_rst_n, por_done} !== {e_tick, e_lvl, e_rst, ~e_rst, e_done}) begin
                errors++;
                $display("FAIL %s edge %0d: tick/lvl/rst/rst_n/done=%b%b%b%b%b expected %b%b%b%b%b",
                         name, ec, tick, tick_level, sys_rst, sys_rst_n, por_done,
                         e_tick, e_lvl, e_rst, ~e_rst, e_done);
            end
        end
    endtask

    task automatic test_free_run();
        int ntick = 0;
        logic e_tick, e_lvl;
        for (int k = 0; k < 40; k++) begin
            step();
            e_tick = (ec % 4 == 0);
            e_lvl  = ((ec / 4) % 2) == 1;
            if (tick) ntick++;
            checks++;
            if ({tick, tick_level} !== {e_tick, e_lvl}) begin
                errors++;
                $display("FAIL free_run edge %0d: tick=%b lvl=%b expected %b %b", ec, tick, tick_level, e_tick, e_lvl);
            end
        end
        checks++;
        if (ntick !== 10) begin
            errors++;
            $display("FAIL free_run_count: got %0d ticks expected 10", ntick);
        end
    endtask

    task automatic test_partial_mask();
        logic [3:0] pats [2];
        pats[0] = 4'b0001;
        pats[1] = 4'b0110;
        align(0);
        for (int p = 0; p < 2; p++) begin
            pb = pats[p];
            for (int k = 0; k < 40; k++) begin
                step();
                checks++;
                if ({sys_rst, sys_rst_n, por_done} !== 3'b011) begin
                    errors++;
                    $display("FAIL partial_mask pb=%b edge %0d: rst/rst_n/done=%b%b%b expected 011",
                             pats[p], ec, sys_rst, sys_rst_n, por_done);
                end
            end
            checks++;
            if (pb_sync !== pats[p]) begin
                errors++;
                $display("FAIL pb_sync_follow: got %b expected %b", pb_sync, pats[p]);
            end
        end
        pb = 4'b0000;
    endtask

    task automatic test_short_combo();
        int base;
        align(0);
        base = ec;
        pb = 4'b1001;
        repeat (4) step();
        checks++;
        if (int'(dut.deb_cnt) !== 1) begin
            errors++;
            $display("FAIL short_deb_one: got %0d expected 1", dut.deb_cnt);
        end
        pb = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (sys_rst !== 1'b0) begin
                errors++;
                $display("FAIL short_no_reset edge %0d: sys_rst=%b expected 0", ec - base, sys_rst);
            end
        end
        checks++;
        if (int'(dut.deb_cnt) !== 0) begin
            errors++;
            $display("FAIL short_deb_clear: got %0d expected 0", dut.deb_cnt);
        end
        pb = 4'b1001;
        repeat (5) step();
        checks++;
        if ({sys_rst, int'(dut.deb_cnt)} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL reapply_one_tick: sys_rst=%b deb=%0d expected 0 1", sys_rst, dut.deb_cnt);
        end
        repeat (2) step();
        checks++;
        if (sys_rst !== 1'b0) begin
            errors++;
            $display("FAIL reapply_before_second: sys_rst=%b expected 0", sys_rst);
        end
        step();
        checks++;
        if (int'(dut.deb_cnt) !== 2) begin
            errors++;
            $display("FAIL reapply_deb_two: got %0d expected 2", dut.deb_cnt);
        end
        step();
        checks++;
        if ({sys_rst, sys_rst_n, por_done} !== 3'b101) begin
            errors++;
            $display("FAIL combo_reset_rise: rst/rst_n/done=%b%b%b expected 101", sys_rst, sys_rst_n, por_done);
        end
    endtask

    task automatic test_combo_hold();
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if ({sys_rst, sys_rst_n, por_done} !== 3'b101) begin
                errors++;
                $display("FAIL combo_hold edge %0d: rst/rst_n/done=%b%b%b expected 101", ec, sys_rst, sys_rst_n, por_done);
            end
        end
        checks++;
        if (int'(dut.deb_cnt) !== 2) begin
            errors++;
            $display("FAIL combo_hold_saturate: got %0d expected 2", dut.deb_cnt);
        end
    endtask

    task automatic test_release();
        int base;
        int ntick = 0;
        align(2);
        base = ec - 2;
        pb = 4'b0000;
        for (int k = 3; k <= 16; k++) begin
            step();
            if (k < 16) begin
                if (tick) ntick++;
                checks++;
                if ({sys_rst, sys_rst_n, por_done} !== 3'b101) begin
                    errors++;
                    $display("FAIL release_high edge +%0d: rst/rst_n/done=%b%b%b expected 101",
                             ec - base, sys_rst, sys_rst_n, por_done);
                end
            end else begin
                checks++;
                if ({tick, sys_rst, sys_rst_n, por_done} !== 4'b1011) begin
                    errors++;
                    $display("FAIL release_drop edge +%0d: tick/rst/rst_n/done=%b%b%b%b expected 1011",
                             ec - base, tick, sys_rst, sys_rst_n, por_done);
                end
            end
        end
        checks++;
        if (ntick !== 3) begin
            errors++;
            $display("FAIL release_tick_count: got %0d expected 3", ntick);
        end
    endtask

    task automatic test_async_reset();
        do_power_on();
        repeat (9) step();
        checks++;
        if (sys_rst !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold_pre: sys_rst=%b expected 1", sys_rst);
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({pb_sync, tick, tick_level, sys_rst, sys_rst_n, por_done} !== 9'b0000_0001_0) begin
            errors++;
            $display("FAIL async_mid_hold: pb_sync=%b tick=%b lvl=%b rst=%b rst_n=%b done=%b, expected 0000 0 0 0 1 0",
                     pb_sync, tick, tick_level, sys_rst, sys_rst_n, por_done);
        end
        test_power_on("power_on_after_hold");
        pb = 4'b1001;
        repeat (12) step();
        checks++;
        if ({sys_rst, por_done} !== 2'b11) begin
            errors++;
            $display("FAIL mid_manual_pre: rst=%b done=%b expected 1 1", sys_rst, por_done);
        end
        #2;
        n_rst = 1'b0;
        pb    = 4'b0000;
        #1;
        checks++;
        if ({pb_sync, tick, tick_level, sys_rst, sys_rst_n, por_done} !== 9'b0000_0001_0) begin
            errors++;
            $display("FAIL async_mid_manual: pb_sync=%b tick=%b lvl=%b rst=%b rst_n=%b done=%b, expected 0000 0 0 0 1 0",
                     pb_sync, tick, tick_level, sys_rst, sys_rst_n, por_done);
        end
        test_power_on("power_on_after_manual");
    endtask

    initial begin
        test_reset();
        test_power_on("power_on");
        test_free_run();
        test_partial_mask();
        test_short_combo();
        test_combo_hold();
        test_release();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
